// File: rtl/rb_fifo_ctrl_pkg.sv
// Shared constants and pointer helper for the register-bank FIFO controller.
package rb_fifo_ctrl_pkg;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_WORD_DEPTH = 18;
    localparam int DEF_ADDR_WIDTH = 5;

    // Modulo-depth increment; the depth need not be a power of two.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rb_fifo_ctrl_if.sv
// Push port, pop port, RAM port and status signals of the FIFO controller.
// master = environment side (producer, consumer, RAM), slave = controller.
interface rb_fifo_ctrl_if
    import rb_fifo_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  IN_VALID;
    logic                  IN_READY;
    logic [WORD_WIDTH-1:0] IN_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [WORD_WIDTH-1:0] OUT_DATA;
    logic                  RAM_WENn;
    logic [ADDR_WIDTH-1:0] RAM_A;
    logic [WORD_WIDTH-1:0] RAM_D;
    logic [WORD_WIDTH-1:0] RAM_Q;
    logic [ADDR_WIDTH-1:0] COUNT;
    logic                  FULL;
    logic                  EMPTY;

    modport master (
        output IN_VALID, IN_DATA, OUT_READY, RAM_Q,
        input  IN_READY, OUT_VALID, OUT_DATA, RAM_WENn, RAM_A, RAM_D,
               COUNT, FULL, EMPTY
    );

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY, RAM_Q,
        output IN_READY, OUT_VALID, OUT_DATA, RAM_WENn, RAM_A, RAM_D,
               COUNT, FULL, EMPTY
    );

endinterface

// File: rtl/rb_fifo_ctrl_ptr_wrap.sv
// rb_ptr_wrap: modulo-DEPTH pointer register with an increment enable.
module rb_ptr_wrap
    import rb_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_WORD_DEPTH,
    parameter int WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_nxt;

    // Next pointer value, wrapping from DEPTH-1 back to 0.
    always_comb begin
        ptr_nxt = WIDTH'(wrap_inc(int'(ptr), DEPTH));
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!RESETn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/rb_fifo_ctrl.sv
// FIFO controller around a single-port register-bank RAM with registered
// read data. Reads take priority over writes; one output holding register
// hides the RAM read latency.
module rb_fifo_ctrl
    import rb_fifo_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic           CLK,
    input logic           RESETn,
    rb_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_V = ADDR_WIDTH'(WORD_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] ram_cnt;
    logic [ADDR_WIDTH-1:0] ram_cnt_nxt;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] count_nxt;
    logic                  rd_inflight;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  full;
    logic                  empty;
    logic                  rd_go;
    logic                  wr_go;
    logic                  in_ready;
    logic                  pop;

    // Port arbitration: a read issues whenever the head slot can take it,
    // and a write only gets the port when no read is issuing.
    always_comb begin
        rd_go    = RESETn && (ram_cnt != '0) && !rd_inflight
                   && (!out_valid || bus.OUT_READY);
        in_ready = RESETn && !full && !rd_go;
        wr_go    = bus.IN_VALID && in_ready;
        pop      = out_valid && bus.OUT_READY;
    end

    // Occupancy arithmetic; wr_go and rd_go are mutually exclusive.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        ram_cnt_nxt = ram_cnt;
        count_nxt   = count;
        if (wr_go) begin
            ram_cnt_nxt = ram_cnt + 1'b1;
        end else if (rd_go) begin
            ram_cnt_nxt = ram_cnt - 1'b1;
        end
        if (wr_go && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !wr_go) begin
            count_nxt = count - 1'b1;
        end
    end

    // RAM port drive: write address on a grant, otherwise park on the read pointer.
    always_comb begin
        bus.RAM_WENn = 1'b1;
        bus.RAM_A    = '0;
        bus.RAM_D    = '0;
        if (wr_go) begin
            bus.RAM_WENn = 1'b0;
            bus.RAM_A    = wptr;
            bus.RAM_D    = bus.IN_DATA;
        end else if (RESETn) begin
            bus.RAM_A    = rptr;
        end
    end

    rb_ptr_wrap #(.DEPTH(WORD_DEPTH), .WIDTH(ADDR_WIDTH)) u_wptr (
        .CLK    (CLK),
        .RESETn (RESETn),
        .inc    (wr_go),
        .ptr    (wptr)
    );

    rb_ptr_wrap #(.DEPTH(WORD_DEPTH), .WIDTH(ADDR_WIDTH)) u_rptr (
        .CLK    (CLK),
        .RESETn (RESETn),
        .inc    (rd_go),
        .ptr    (rptr)
    );

    // Counters, read-in-flight flag, output holding register and status flags.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ram_cnt     <= '0;
            count       <= '0;
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            ram_cnt     <= ram_cnt_nxt;
            count       <= count_nxt;
            rd_inflight <= rd_go;
            if (rd_inflight) begin
                out_valid <= 1'b1;
                out_data  <= bus.RAM_Q;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            full  <= (ram_cnt_nxt == DEPTH_V);
            empty <= (count_nxt == '0);
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;
    assign bus.COUNT     = count;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;

endmodule
